uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised, synthesizable UART receiver with an internal oversampling tick generator, configurable frame format (data bits, parity, stop bits), majority-vote sampling and a first-word-fall-through receive FIFO. It sits on the core's peripheral bus behind the MMIO decoder and replaces fixed 8N1, 16x, single-byte receive logic. It flags parity, framing and overrun errors.

## Interface
- `BAUD_DIV`, 27: `clk` cycles per oversample tick (50 MHz / (115200 × 16) ≈ 27); must be ≥ 1.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `DATA_BITS`, 8: payload width, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two, ≥ 2.
- `clk`  in  1  Core clock. One clock domain.
- `Rst`  in  1  Reset; synchronous, active-high.
- `rx`  in  1  Serial input; asynchronous; idle high.
- `rd_en`  in  1  Pop the FIFO head. Ignored when `valid` = 0.
- `clr_err`  in  1  Clears all sticky error flags.
- `dout`  out  DATA_BITS  FIFO head. Valid when `valid` = 1.
- `valid`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `parity_err`, `frame_err`, `overrun`  out  1 each  Sticky error flags.

## Operation
- `rx` passes through a 2-FF synchroniser, giving `rx_s`. All decisions use `rx_s`.
- **Tick generator:**
  - A counter runs from `BAUD_DIV-1` down to 0.
  - `tick` is asserted for one cycle at 0, then the counter reloads.
  - The counter runs freely except in IDLE, where it is held at `BAUD_DIV-1`. The first tick therefore occurs `BAUD_DIV` cycles after START is entered.
- **Sampling:**
  - The sub-tick counter `s` counts 0..OVERSAMPLE-1 within each bit.
  - The bit value is the majority of `rx_s` captured at ticks `s` = OS/2-1, OS/2 and OS/2+1.
- **States:** IDLE, START, DATA, PAR, STOP.
  - IDLE: requires `armed` = 1, where `armed` is set after `rx_s` = 1 is seen for at least one cycle. On `rx_s` = 0, go to START with `s` = 0.
  - START: if the majority at mid-bit is 1, this is a glitch; go to IDLE with no flags. Otherwise continue to the end of the bit, then go to DATA.
  - DATA: shift in LSB first. After `DATA_BITS` bits, go to PAR if `PARITY` ≠ 0, else to STOP.
  - PAR: compare the received bit against odd/even parity of the data. On mismatch, set `perr_frame`.
  - STOP: each stop bit majority must be 1.
- **End of frame:** the frame ends at the mid-bit (`s` = OS/2+1) of the last stop bit, then the FSM goes to IDLE. The remaining half bit is not waited out, so back-to-back frames are supported.
  - Any stop bit = 0: set `frame_err`, discard the byte, and clear `armed` (a break condition needs `rx` high again).
  - Parity error with a good stop: push the byte and set `parity_err`.
  - Push while full with no `rd_en` that cycle: drop the new byte and set `overrun`. FIFO contents are unchanged.
  - Push and `rd_en` while full in the same cycle: both take effect; `count` is unchanged.
- **Error flags:** set flags hold until `clr_err`. If `clr_err` and a new error occur in the same cycle, set wins.
- **Reset:** `Rst` at any time, including mid-frame, puts the FSM in IDLE, empties the FIFO and clears `armed`, the counters and all flags. A frame already in progress when reset releases is ignored until `rx` returns high.
- **Reset values:** `dout` = 0, `valid` = 0, `count` = 0, all flags 0.

## Timing
- Synchroniser latency is 2 cycles.
- Push occurs in the cycle after the final stop-bit mid-sample tick.
  - `valid` and `dout` are updated 1 cycle after the push.
  - Measured from the falling edge of `rx`: 2 + BAUD_DIV × (OVERSAMPLE × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 1) + OS/2+2) cycles, ±1.
- `rd_en` at edge *n*: the next head appears on `dout` at *n*+1. `valid` falls at *n*+1 if the FIFO is now empty.
- `dout` is registered and has no combinational path from `rd_en`.

## Structure
- Package `uart_pkg`:
  - `parity_e` enum: PAR_NONE, PAR_ODD, PAR_EVEN.
  - `rx_state_e` enum: IDLE, START, DATA, PAR, STOP.
  - Localparams for the sample offsets.
- Sub-module `sync_fifo`, parameters WIDTH and DEPTH:
  - Registered FWFT output; ports `push`, `pop`, `din`, `dout`, `empty`, `full`, `count`.
  - Simultaneous push and pop are legal when full or empty (push only when empty).
- Top-level owns the synchroniser, tick generator, FSM, shift register and flags.

## Test plan
All tests use BAUD_DIV=2 and OS=16, so one bit = 32 cycles.
- 8N1, send 0x61 0x62 0x63 0x64 back-to-back, no reads → `count` = 4, `dout` = 0x61. Four pops yield a,b,c,d and `valid` = 0.
- Send a 5th byte 0x65 while full → `overrun` = 1, head still 0x61. `clr_err` → `overrun` = 0.
- PARITY=2 (even), 0x07 with parity bit 0 → byte pushed, `parity_err` = 1. Same data with parity bit 1 → no error.
- Stop bit forced 0 on 0xA5 → `frame_err` = 1, `count` unchanged. Then hold `rx` low for 20 bits and release → no new byte.
- 8-cycle low glitch on idle `rx` → FSM returns to IDLE, no push, no flags.
- Assert `Rst` at data bit 4 of 0x3C → outputs all 0. The remainder of that frame is ignored, and the next full frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared enums, sample offsets and helpers for the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} rx_state_e;
  localparam int SMP_EARLY_OFS = -1;
  localparam int SMP_LATE_OFS = 1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a | b));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered head output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd, w_rd_next;
  logic [AW:0] r_count, w_left;
  logic w_push, w_pop;
  assign empty = r_count == '0;
  assign full = r_count == (AW+1)'(DEPTH);
  assign count = r_count;
  assign w_pop = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign w_rd_next = r_rd + AW'(w_pop);
  assign w_left = r_count - (AW+1)'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  // The head register is loaded with whatever will be at the front after this cycle's pop/push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      dout <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= w_rd_next;
      r_count <= w_left + (AW+1)'(w_push);
      if (w_left != '0) dout <= r_mem[w_rd_next];
      else if (w_push) dout <= din;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with configurable framing,
// majority-vote sampling, sticky error flags and a FWFT receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic Rst,
  input  logic rx,
  input  logic rd_en,
  input  logic clr_err,
  output logic [DATA_BITS-1:0] dout,
  output logic valid,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic parity_err,
  output logic frame_err,
  output logic overrun
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam int S_CTR = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_EARLY = SW'(S_CTR + SMP_EARLY_OFS);
  localparam logic [SW-1:0] S_MID = SW'(S_CTR);
  localparam logic [SW-1:0] S_LATE = SW'(S_CTR + SMP_LATE_OFS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam parity_e PMODE = parity_e'(PARITY);
  rx_state_e r_state, w_next;
  logic [1:0] r_sync, r_smp;
  logic [BW-1:0] r_baud;
  logic [SW-1:0] r_s;
  logic [NW-1:0] r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic r_stop, r_armed, r_perr, r_ferr, r_push, r_push_perr;
  logic w_rx_s, w_tick, w_mid, w_end, w_maj, w_par_exp, w_done, w_bad, w_pop, w_full, w_empty;
  assign w_rx_s = r_sync[1];
  assign w_tick = r_state != IDLE && r_baud == '0;
  assign w_mid = w_tick && r_s == S_LATE;
  assign w_end = w_tick && r_s == S_LAST;
  assign w_maj = maj3(r_smp[0], r_smp[1], w_rx_s);
  assign w_par_exp = (PMODE == PAR_ODD) ? ~^r_shift : ^r_shift;
  assign w_bad = r_ferr | ~w_maj;
  assign w_pop = rd_en & valid;
  assign valid = ~w_empty;
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:  if (r_armed && !w_rx_s) w_next = START;
      START: if (w_mid && w_maj) w_next = IDLE; else if (w_end) w_next = DATA;
      DATA:  if (w_end && r_bit == NW'(DATA_BITS)) w_next = (PMODE == PAR_NONE) ? STOP : PAR;
      PAR:   if (w_end) w_next = STOP;
      STOP:  if (w_mid && r_stop == 1'(STOP_BITS - 1)) begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_sync <= '0;
      r_smp <= '0;
      r_baud <= BW'(BAUD_DIV - 1);
      r_s <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_stop <= 1'b0;
      r_armed <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_push <= 1'b0;
      r_push_perr <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync <= {r_sync[0], rx};
      r_baud <= (r_state == IDLE || w_tick) ? BW'(BAUD_DIV - 1) : r_baud - BW'(1);
      r_s <= (r_state == IDLE || w_end) ? '0 : r_s + SW'(w_tick);
      if (w_tick && r_s == S_EARLY) r_smp[0] <= w_rx_s;
      if (w_tick && r_s == S_MID) r_smp[1] <= w_rx_s;
      r_bit <= (r_state == DATA) ? r_bit + NW'(w_mid) : '0;
      r_stop <= (r_state == STOP) ? r_stop ^ w_end : 1'b0;
      if (r_state == DATA && w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      r_perr <= (r_state == START) ? 1'b0 : (r_state == PAR && w_mid) ? (w_maj != w_par_exp) : r_perr;
      r_ferr <= (r_state == START) ? 1'b0 : r_ferr | (r_state == STOP && w_mid && !w_maj);
      // A bad stop may be a break: stay disarmed until the line is seen high again
      r_armed <= (w_done && w_bad) ? 1'b0 : r_armed | w_rx_s;
      r_push <= w_done && !w_bad;
      r_push_perr <= w_done && !w_bad && r_perr;
      parity_err <= r_push_perr | (parity_err & ~clr_err);
      frame_err <= (w_done & w_bad) | (frame_err & ~clr_err);
      overrun <= (r_push & w_full & ~w_pop) | (overrun & ~clr_err);
    end
  end
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(Rst),
    .push(r_push),
    .pop(w_pop),
    .din(r_shift),
    .dout(dout),
    .empty(w_empty),
    .full(w_full),
    .count(count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for an 8N1 and an 8E1 receiver
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_n = 1'b1, rx_e = 1'b1, rd_n = 1'b0, rd_e = 1'b0, clr_n = 1'b0, clr_e = 1'b0;
  logic [7:0] dout_n, dout_e;
  logic valid_n, valid_e, perr_n, ferr_n, ovr_n, perr_e, ferr_e, ovr_e;
  logic [2:0] count_n, count_e;
  int n_tests = 0, n_fail = 0;
  logic [7:0] q_n[$];
  always #5 clk = ~clk;
  uart_rx_fifo #(.BAUD_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
    .clk(clk), .Rst(rst), .rx(rx_n), .rd_en(rd_n), .clr_err(clr_n), .dout(dout_n), .valid(valid_n),
    .count(count_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n));
  uart_rx_fifo #(.BAUD_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .Rst(rst), .rx(rx_e), .rd_en(rd_e), .clr_err(clr_e), .dout(dout_e), .valid(valid_e),
    .count(count_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e));
  task automatic drive_bit(input bit sel, input logic b, input int cycles);
    if (sel) rx_e = b; else rx_n = b;
    repeat (cycles) @(negedge clk);
  endtask
  task automatic send_n(input logic [7:0] d, input logic stop);
    drive_bit(0, 1'b0, 32);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i], 32);
    drive_bit(0, stop, 32);
  endtask
  task automatic send_e(input logic [7:0] d, input logic p);
    drive_bit(1, 1'b0, 32);
    for (int i = 0; i < 8; i++) drive_bit(1, d[i], 32);
    drive_bit(1, p, 32);
    drive_bit(1, 1'b1, 32);
  endtask
  task automatic pop_n();
    rd_n = 1'b1; @(negedge clk); rd_n = 1'b0;
  endtask
  task automatic pop_e();
    rd_e = 1'b1; @(negedge clk); rd_e = 1'b0;
  endtask
  task automatic clear_both();
    clr_n = 1'b1; clr_e = 1'b1; @(negedge clk); clr_n = 1'b0; clr_e = 1'b0;
  endtask
  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_tests++; if (count_n !== 3'd0) begin n_fail++; $display("FAIL reset_count_n got %0d want 0", count_n); end
    n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL reset_valid_n got %b want 0", valid_n); end
    n_tests++; if (dout_n !== 8'h00) begin n_fail++; $display("FAIL reset_dout_n got %h want 00", dout_n); end
    n_tests++; if ({perr_n, ferr_n, ovr_n} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_n got %b want 000", {perr_n, ferr_n, ovr_n}); end
    n_tests++; if (count_e !== 3'd0) begin n_fail++; $display("FAIL reset_count_e got %0d want 0", count_e); end
    n_tests++; if (valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_valid_e got %b want 0", valid_e); end
    n_tests++; if (dout_e !== 8'h00) begin n_fail++; $display("FAIL reset_dout_e got %h want 00", dout_e); end
    n_tests++; if ({perr_e, ferr_e, ovr_e} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_e got %b want 000", {perr_e, ferr_e, ovr_e}); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) send_n(8'h61 + 8'(i), 1'b1);
    drive_bit(0, 1'b1, 4);
    n_tests++; if (count_n !== 3'd4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", count_n); end
    n_tests++; if (dout_n !== 8'h61) begin n_fail++; $display("FAIL b2b_head got %h want 61", dout_n); end
    send_n(8'h65, 1'b1);
    drive_bit(0, 1'b1, 4);
    n_tests++; if (ovr_n !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", ovr_n); end
    n_tests++; if (dout_n !== 8'h61) begin n_fail++; $display("FAIL overrun_head got %h want 61", dout_n); end
    n_tests++; if (count_n !== 3'd4) begin n_fail++; $display("FAIL overrun_count got %0d want 4", count_n); end
    clear_both();
    n_tests++; if (ovr_n !== 1'b0) begin n_fail++; $display("FAIL overrun_clr got %b want 0", ovr_n); end
    for (int i = 0; i < 4; i++) begin
      e = 8'h61 + 8'(i);
      n_tests++; if (valid_n !== 1'b1 || dout_n !== e) begin n_fail++; $display("FAIL b2b_pop%0d got %b/%h want 1/%h", i, valid_n, dout_n, e); end
      pop_n();
    end
    n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", valid_n); end
  endtask
  task automatic test_random_8n1();
    logic [7:0] d;
    logic exp_ovr;
    exp_ovr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      send_n(d, 1'b1);
      drive_bit(0, 1'b1, 2);
      if (q_n.size() < 4) q_n.push_back(d); else exp_ovr = 1'b1;
      n_tests++; if (count_n !== 3'(q_n.size())) begin n_fail++; $display("FAIL rand_count%0d got %0d want %0d", k, count_n, q_n.size()); end
      n_tests++; if (ovr_n !== exp_ovr) begin n_fail++; $display("FAIL rand_ovr%0d got %b want %b", k, ovr_n, exp_ovr); end
      n_tests++; if (dout_n !== q_n[0]) begin n_fail++; $display("FAIL rand_head%0d got %h want %h", k, dout_n, q_n[0]); end
      if ($urandom_range(0, 2) != 0) begin
        pop_n();
        void'(q_n.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_both();
        exp_ovr = 1'b0;
      end
    end
    while (q_n.size() > 0) begin
      n_tests++; if (dout_n !== q_n[0]) begin n_fail++; $display("FAIL rand_drain got %h want %h", dout_n, q_n[0]); end
      pop_n();
      void'(q_n.pop_front());
    end
    n_tests++; if (valid_n !== 1'b0) begin n_fail++; $display("FAIL rand_empty got %b want 0", valid_n); end
    clear_both();
  endtask
  task automatic test_parity();
    logic [7:0] d;
    logic bad;
    send_e(8'h07, 1'b0);
    drive_bit(1, 1'b1, 2);
    n_tests++; if (count_e !== 3'd1 || dout_e !== 8'h07) begin n_fail++; $display("FAIL par_bad_push got %0d/%h want 1/07", count_e, dout_e); end
    n_tests++; if (perr_e !== 1'b1) begin n_fail++; $display("FAIL par_bad_flag got %b want 1", perr_e); end
    pop_e();
    clear_both();
    n_tests++; if (perr_e !== 1'b0) begin n_fail++; $display("FAIL par_clr got %b want 0", perr_e); end
    send_e(8'h07, 1'b1);
    drive_bit(1, 1'b1, 2);
    n_tests++; if (perr_e !== 1'b0 || dout_e !== 8'h07 || count_e !== 3'd1) begin n_fail++; $display("FAIL par_good got %b/%h/%0d want 0/07/1", perr_e, dout_e, count_e); end
    pop_e();
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      bad = 1'($urandom_range(0, 1));
      send_e(d, ($countones(d) % 2 == 1) ^ bad);
      drive_bit(1, 1'b1, 2);
      n_tests++; if (dout_e !== d || count_e !== 3'd1) begin n_fail++; $display("FAIL par_rand_data%0d got %h/%0d want %h/1", k, dout_e, count_e, d); end
      n_tests++; if (perr_e !== bad || ferr_e !== 1'b0) begin n_fail++; $display("FAIL par_rand_flag%0d got %b/%b want %b/0", k, perr_e, ferr_e, bad); end
      pop_e();
      clear_both();
    end
  endtask
  task automatic test_frame_break();
    send_n(8'h11, 1'b1);
    send_n(8'hA5, 1'b0);
    n_tests++; if (ferr_n !== 1'b1) begin n_fail++; $display("FAIL frame_flag got %b want 1", ferr_n); end
    n_tests++; if (count_n !== 3'd1 || dout_n !== 8'h11) begin n_fail++; $display("FAIL frame_count got %0d/%h want 1/11", count_n, dout_n); end
    drive_bit(0, 1'b0, 20 * 32);
    drive_bit(0, 1'b1, 64);
    n_tests++; if (count_n !== 3'd1) begin n_fail++; $display("FAIL break_count got %0d want 1", count_n); end
    clear_both();
    n_tests++; if (ferr_n !== 1'b0) begin n_fail++; $display("FAIL frame_clr got %b want 0", ferr_n); end
  endtask
  task automatic test_glitch();
    drive_bit(0, 1'b0, 8);
    drive_bit(0, 1'b1, 80);
    n_tests++; if (count_n !== 3'd1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", count_n); end
    n_tests++; if ({perr_n, ferr_n, ovr_n} !== 3'b000) begin n_fail++; $display("FAIL glitch_flags got %b want 000", {perr_n, ferr_n, ovr_n}); end
    send_n(8'h5A, 1'b1);
    drive_bit(0, 1'b1, 2);
    n_tests++; if (count_n !== 3'd2 || dout_n !== 8'h11) begin n_fail++; $display("FAIL glitch_next got %0d/%h want 2/11", count_n, dout_n); end
  endtask
  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h3C;
    send_e(8'h07, 1'b0);
    drive_bit(0, 1'b0, 32);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], 32);
    drive_bit(0, d[4], 16);
    rst = 1'b1;
    drive_bit(0, d[4], 16);
    drive_bit(0, d[5], 32);
    drive_bit(0, d[6], 32);
    n_tests++; if ({count_n, valid_n, dout_n} !== 12'h0) begin n_fail++; $display("FAIL rst_mid_out_n got %0d/%b/%h want 0/0/00", count_n, valid_n, dout_n); end
    n_tests++; if ({count_e, valid_e, dout_e} !== 12'h0) begin n_fail++; $display("FAIL rst_mid_out_e got %0d/%b/%h want 0/0/00", count_e, valid_e, dout_e); end
    n_tests++; if ({perr_n, ferr_n, ovr_n, perr_e, ferr_e, ovr_e} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_flags got %b want 000000", {perr_n, ferr_n, ovr_n, perr_e, ferr_e, ovr_e}); end
    drive_bit(0, d[7], 16);
    rst = 1'b0;
    drive_bit(0, d[7], 16);
    drive_bit(0, 1'b1, 96);
    n_tests++; if (count_n !== 3'd0 || ferr_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ignored got %0d/%b want 0/0", count_n, ferr_n); end
    send_n(8'h55, 1'b1);
    drive_bit(0, 1'b1, 2);
    n_tests++; if (count_n !== 3'd1 || dout_n !== 8'h55) begin n_fail++; $display("FAIL rst_mid_next got %0d/%h want 1/55", count_n, dout_n); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_random_8n1();
    test_parity();
    test_frame_break();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
